// File: rtl/orb_m16_deframer.sv
// orb_m16_deframer
//   Receive side of the M16 orbit link. Recovers NRZ bits from the orbit pin,
//   hunts for the frame marker, and then slices the bit stream into 12-bit
//   telemetry words tagged with their in-frame address.
//
// Ports
//   clk          system clock (clk80MHz)
//   rst          asynchronous active-low reset
//   iOrb         serial orbit line, MSB first, asynchronous to clk
//   oWord        recovered word, held until the next strobe
//   oAddr        word index within the frame, 0 = marker
//   oValid       one-clk strobe, oWord/oAddr valid
//   oFrameStart  one-clk strobe with word 0 when the marker matched
//   oSyncErr     one-clk strobe with word 0 when the marker mismatched while locked
//   oLock        high while frame-locked
//   oFrameCnt    good-marker counter, wraps 255 -> 0
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_HUNT | sliding 12-bit window compared to SYNC_WORD on every bit
// ST_LOCK | word-aligned; a word is emitted every 12 bits, marker checked at addr 0

module orb_m16_deframer #(
  parameter int unsigned BIT_DIV     = 16,
  parameter logic [11:0] SYNC_WORD   = 12'hE27,
  parameter int unsigned FRAME_WORDS = 2048,
  parameter int unsigned MISS_MAX    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iOrb,
  output logic [11:0] oWord,
  output logic [10:0] oAddr,
  output logic        oValid,
  output logic        oFrameStart,
  output logic        oSyncErr,
  output logic        oLock,
  output logic [7:0]  oFrameCnt
);

  localparam int unsigned PH_W   = $clog2(BIT_DIV);
  localparam int unsigned MISS_W = $clog2(MISS_MAX + 1);

  localparam logic [PH_W-1:0]   PH_SAMPLE = PH_W'(BIT_DIV / 2 - 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(BIT_DIV - 1);
  localparam logic [10:0]       ADDR_MASK = 11'(FRAME_WORDS - 1);
  localparam logic [MISS_W-1:0] MISS_LIM  = MISS_W'(MISS_MAX);

  typedef enum logic {ST_HUNT, ST_LOCK} state_t;

  state_t            state_q;
  logic [2:0]        sync_q;
  logic [PH_W-1:0]   phase_q;
  // Only the 11 older bits are stored; the full 12-bit window is shift_d.
  logic [10:0]       shift_q;
  logic [3:0]        bit_cnt_q;
  logic [10:0]       word_cnt_q;
  logic [MISS_W-1:0] miss_cnt_q;
  logic [11:0]       word_q;
  logic [10:0]       addr_q;
  logic              valid_q;
  logic              fstart_q;
  logic              serr_q;
  logic [7:0]        fcnt_q;

  logic              orb_edge;
  logic              bit_stb;
  logic [PH_W-1:0]   phase_d;
  logic [11:0]       shift_d;
  logic [MISS_W-1:0] miss_d;

  // sync_q[1] is the synchronized level; sync_q[2] is its delayed copy.
  assign orb_edge = sync_q[1] ^ sync_q[2];
  // An edge on the sample phase realigns the bit instead of sampling it.
  assign bit_stb  = !orb_edge && (phase_q == PH_SAMPLE);
  assign shift_d  = {shift_q, sync_q[1]};
  assign miss_d   = miss_cnt_q + MISS_W'(1);

  always_comb begin
    phase_d = phase_q + PH_W'(1);
    if (orb_edge || phase_q == PH_LAST) phase_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_HUNT;
      sync_q     <= '0;
      phase_q    <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      miss_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      fstart_q   <= 1'b0;
      serr_q     <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      sync_q   <= {sync_q[1:0], iOrb};
      phase_q  <= phase_d;
      valid_q  <= 1'b0;
      fstart_q <= 1'b0;
      serr_q   <= 1'b0;
      if (bit_stb) begin
        shift_q <= shift_d[10:0];
        case (state_q)
          ST_HUNT: begin
            if (shift_d == SYNC_WORD) begin
              state_q    <= ST_LOCK;
              valid_q    <= 1'b1;
              fstart_q   <= 1'b1;
              word_q     <= shift_d;
              addr_q     <= '0;
              fcnt_q     <= fcnt_q + 8'd1;
              word_cnt_q <= 11'd1 & ADDR_MASK;
              bit_cnt_q  <= '0;
              miss_cnt_q <= '0;
            end
          end
          ST_LOCK: begin
            if (bit_cnt_q == 4'd11) begin
              bit_cnt_q  <= '0;
              valid_q    <= 1'b1;
              word_q     <= shift_d;
              addr_q     <= word_cnt_q;
              word_cnt_q <= (word_cnt_q + 11'd1) & ADDR_MASK;
              if (word_cnt_q == 11'd0) begin
                if (shift_d == SYNC_WORD) begin
                  fstart_q   <= 1'b1;
                  fcnt_q     <= fcnt_q + 8'd1;
                  miss_cnt_q <= '0;
                end else begin
                  serr_q     <= 1'b1;
                  miss_cnt_q <= miss_d;
                  if (miss_d == MISS_LIM) state_q <= ST_HUNT;
                end
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          default: state_q <= ST_HUNT;
        endcase
      end
    end
  end

  assign oWord       = word_q;
  assign oAddr       = addr_q;
  assign oValid      = valid_q;
  assign oFrameStart = fstart_q;
  assign oSyncErr    = serr_q;
  assign oLock       = (state_q == ST_LOCK);
  assign oFrameCnt   = fcnt_q;

endmodule

// File: tb/tb_orb_m16_deframer.sv
// Bench for orb_m16_deframer. Frames are shortened (FRAME_WORDS=16) so the
// whole run stays small; the bit rate is the nominal BIT_DIV=16.
module tb_orb_m16_deframer;

  localparam int          BIT_DIV  = 16;
  localparam int          FW       = 16;
  localparam int          MISS_MAX = 2;
  localparam logic [11:0] SYNC     = 12'hE27;

  typedef struct packed {
    logic [10:0] addr;
    logic [11:0] word;
    logic        fs;
    logic        se;
    logic        lock;
    logic [7:0]  fcnt;
    logic        valid;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iOrb = 1'b0;
  logic [11:0] oWord;
  logic [10:0] oAddr;
  logic        oValid, oFrameStart, oSyncErr, oLock;
  logic [7:0]  oFrameCnt;

  ev_t         got_q[$];
  ev_t         exp_q[$];
  int          got_cyc[$];
  bit          tx_bits[$];
  int          tx_per[$];
  bit          jitter = 1'b0;
  bit          jit_ph = 1'b0;
  bit          cap_en = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  orb_m16_deframer #(
    .BIT_DIV(BIT_DIV), .SYNC_WORD(SYNC), .FRAME_WORDS(FW), .MISS_MAX(MISS_MAX)
  ) dut (
    .clk(clk), .rst(rst), .iOrb(iOrb), .oWord(oWord), .oAddr(oAddr),
    .oValid(oValid), .oFrameStart(oFrameStart), .oSyncErr(oSyncErr),
    .oLock(oLock), .oFrameCnt(oFrameCnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cap_en && (oValid || oFrameStart || oSyncErr)) begin
      ev_t e;
      e.addr = oAddr; e.word = oWord; e.fs = oFrameStart; e.se = oSyncErr;
      e.lock = oLock; e.fcnt = oFrameCnt; e.valid = oValid;
      got_q.push_back(e);
      got_cyc.push_back(cyc);
    end
  end

  function automatic string fmt_ev(ev_t e);
    return $sformatf("a=%0d w=%h fs=%b se=%b lk=%b fc=%0d v=%b",
                     e.addr, e.word, e.fs, e.se, e.lock, e.fcnt, e.valid);
  endfunction

  // ---- stimulus construction ----
  task automatic add_bit(input bit b);
    tx_bits.push_back(b);
    if (jitter) begin
      tx_per.push_back(jit_ph ? 17 : 15);
      jit_ph = !jit_ph;
    end else begin
      tx_per.push_back(BIT_DIV);
    end
  endtask

  task automatic add_word(input logic [11:0] w);
    for (int i = 11; i >= 0; i--) add_bit(w[i]);
  endtask

  // Data words keep their top nibble clear, so no 12-bit window of the
  // stream can alias the marker except where it is deliberately placed.
  task automatic add_frame(input logic [11:0] marker, input int false_at, input bit ramp);
    add_word(marker);
    for (int a = 1; a < FW; a++) begin
      if (a == false_at)  add_word(SYNC);
      else if (ramp)      add_word(12'(a));
      else                add_word(12'($urandom_range(0, 255)));
    end
  endtask

  task automatic start_stream();
    tx_bits.delete(); tx_per.delete(); got_q.delete(); got_cyc.delete();
    jit_ph = 1'b0;
    for (int i = 0; i < 4; i++) add_bit(1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0; iOrb = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_stream();
    cap_en = 1'b1;
    foreach (tx_bits[i]) begin
      iOrb = tx_bits[i];
      repeat (tx_per[i]) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    cap_en = 1'b0;
  endtask

  // ---- reference model: marker search then fixed 12-bit slicing ----
  function automatic logic [11:0] window_at(int i);
    logic [11:0] w = '0;
    for (int b = 0; b < 12; b++) if (i - b >= 0) w[b] = tx_bits[i - b];
    return w;
  endfunction

  task automatic model_run();
    int         n = tx_bits.size();
    int         i = 0;
    int         j, k, miss;
    logic [7:0] fc = '0;
    ev_t        e;
    exp_q.delete();
    while (i < n) begin
      if (window_at(i) != SYNC) begin
        i++;
      end else begin
        fc++; miss = 0;
        e.addr = '0; e.word = SYNC; e.fs = 1; e.se = 0; e.lock = 1; e.fcnt = fc; e.valid = 1;
        exp_q.push_back(e);
        k = 1; j = i + 12; i = n;
        while (j < n) begin
          e.addr = 11'(k % FW); e.word = window_at(j); e.fs = 0; e.se = 0; e.lock = 1; e.valid = 1;
          if (k % FW == 0) begin
            if (e.word == SYNC) begin
              e.fs = 1; fc++; miss = 0;
            end else begin
              e.se = 1; miss++;
              if (miss == MISS_MAX) e.lock = 0;
            end
          end
          e.fcnt = fc;
          exp_q.push_back(e);
          if (!e.lock) begin
            i = j + 1;
            break;
          end
          k++; j += 12;
        end
      end
    end
  endtask

  // ---- tests ----
  task automatic test_acquire();
    do_reset();
    start_stream();
    add_frame(SYNC, 0, 1'b1);
    run_stream();
    model_run();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL acq_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL acq_ev[%0d]: got %s / want %s", i, fmt_ev(got_q[i]), fmt_ev(exp_q[i]));
      end
    end
    for (int i = 1; i < got_cyc.size(); i++) begin
      n_cmp++;
      if (got_cyc[i] - got_cyc[i-1] != 12 * BIT_DIV) begin
        n_err++; $display("FAIL acq_spacing[%0d]: got %0d clks, want %0d", i, got_cyc[i] - got_cyc[i-1], 12 * BIT_DIV);
      end
    end
    n_cmp++;
    if ({oLock, oFrameCnt, oAddr, oWord} !== {1'b1, 8'd1, 11'd15, 12'h00F}) begin
      n_err++; $display("FAIL acq_final: got lock=%b fc=%0d a=%0d w=%h, want lock=1 fc=1 a=15 w=00f",
                        oLock, oFrameCnt, oAddr, oWord);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({oWord, oAddr, oValid, oFrameStart, oSyncErr, oLock, oFrameCnt} !== '0) begin
      n_err++; $display("FAIL rst_async: got w=%h a=%0d lk=%b fc=%0d, want all 0", oWord, oAddr, oLock, oFrameCnt);
    end
    for (int c = 0; c < 24; c++) begin
      iOrb = 1'($urandom);
      @(negedge clk);
      if (c % 4 == 3) begin
        n_cmp++;
        if ({oWord, oAddr, oValid, oFrameStart, oSyncErr, oLock, oFrameCnt} !== '0) begin
          n_err++; $display("FAIL rst_hold[%0d]: got w=%h a=%0d v=%b lk=%b fc=%0d, want all 0",
                            c, oWord, oAddr, oValid, oLock, oFrameCnt);
        end
      end
    end
    iOrb = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    start_stream();
    for (int i = 0; i < 60; i++) add_bit(1'($urandom));
    run_stream();
    model_run();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rst_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL rst_ev[%0d]: got %s / want %s", i, fmt_ev(got_q[i]), fmt_ev(exp_q[i]));
      end
    end
  endtask

  task automatic test_false_marker();
    do_reset();
    start_stream();
    add_frame(SYNC, 0, 1'b0);
    add_frame(SYNC, 10, 1'b0);
    run_stream();
    model_run();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL fm_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL fm_ev[%0d]: got %s / want %s", i, fmt_ev(got_q[i]), fmt_ev(exp_q[i]));
      end
    end
    n_cmp++;
    if (got_q.size() <= FW + 10) begin
      n_err++; $display("FAIL fm_data: got %0d events, want more than %0d", got_q.size(), FW + 10);
    end else if ({got_q[FW+10].addr, got_q[FW+10].word, got_q[FW+10].fs} !== {11'd10, SYNC, 1'b0}) begin
      n_err++; $display("FAIL fm_data: got %s, want a=10 w=e27 fs=0", fmt_ev(got_q[FW+10]));
    end
    n_cmp++;
    if ({oLock, oFrameCnt, oAddr} !== {1'b1, 8'd2, 11'(FW - 1)}) begin
      n_err++; $display("FAIL fm_final: got lock=%b fc=%0d a=%0d, want lock=1 fc=2 a=%0d", oLock, oFrameCnt, oAddr, FW - 1);
    end
  endtask

  task automatic test_sync_loss();
    int nse = 0;
    int nfs = 0;
    do_reset();
    start_stream();
    add_frame(SYNC, 0, 1'b0);
    add_frame(12'h000, 0, 1'b0);
    add_frame(12'h000, 0, 1'b0);
    add_frame(SYNC, 0, 1'b0);
    run_stream();
    model_run();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL loss_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL loss_ev[%0d]: got %s / want %s", i, fmt_ev(got_q[i]), fmt_ev(exp_q[i]));
      end
    end
    foreach (got_q[i]) begin
      if (got_q[i].se) nse++;
      if (got_q[i].fs) nfs++;
    end
    n_cmp++;
    if (nse != 2 || nfs != 2 || got_q.size() != 3 * FW + 1) begin
      n_err++; $display("FAIL loss_tally: got se=%0d fs=%0d ev=%0d, want se=2 fs=2 ev=%0d", nse, nfs, got_q.size(), 3 * FW + 1);
    end else if (got_q[2*FW].lock !== 1'b0 || got_q[2*FW+1].addr !== 11'd0) begin
      n_err++; $display("FAIL loss_drop: got drop %s relock %s", fmt_ev(got_q[2*FW]), fmt_ev(got_q[2*FW+1]));
    end
    n_cmp++;
    if ({oLock, oFrameCnt} !== {1'b1, 8'd2}) begin
      n_err++; $display("FAIL loss_final: got lock=%b fc=%0d, want lock=1 fc=2", oLock, oFrameCnt);
    end
  endtask

  task automatic test_single_miss();
    int nse = 0;
    do_reset();
    start_stream();
    add_frame(SYNC, 0, 1'b0);
    add_frame(12'h5A5, 0, 1'b0);
    add_frame(SYNC, 0, 1'b0);
    run_stream();
    model_run();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL miss_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL miss_ev[%0d]: got %s / want %s", i, fmt_ev(got_q[i]), fmt_ev(exp_q[i]));
      end
    end
    foreach (got_q[i]) if (got_q[i].se) nse++;
    n_cmp++;
    if (nse != 1 || {oLock, oFrameCnt} !== {1'b1, 8'd2}) begin
      n_err++; $display("FAIL miss_final: got se=%0d lock=%b fc=%0d, want se=1 lock=1 fc=2", nse, oLock, oFrameCnt);
    end
  endtask

  task automatic test_jitter();
    int nse = 0;
    jitter = 1'b1;
    do_reset();
    start_stream();
    for (int f = 0; f < 3; f++) add_frame(SYNC, 0, 1'b0);
    run_stream();
    model_run();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL jit_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL jit_ev[%0d]: got %s / want %s", i, fmt_ev(got_q[i]), fmt_ev(exp_q[i]));
      end
    end
    foreach (got_q[i]) if (got_q[i].se) nse++;
    n_cmp++;
    if (nse != 0 || {oLock, oFrameCnt} !== {1'b1, 8'd3}) begin
      n_err++; $display("FAIL jit_final: got se=%0d lock=%b fc=%0d, want se=0 lock=1 fc=3", nse, oLock, oFrameCnt);
    end

    // Reset lands partway through word 10 of the second frame; the last
    // bit is cut short so it is never sampled.
    do_reset();
    start_stream();
    add_frame(SYNC, 0, 1'b0);
    add_word(SYNC);
    for (int a = 1; a < 10; a++) add_word(12'($urandom_range(0, 255)));
    for (int b = 0; b < 7; b++) add_bit(1'($urandom));
    cap_en = 1'b1;
    for (int i = 0; i < tx_bits.size() - 1; i++) begin
      iOrb = tx_bits[i];
      repeat (tx_per[i]) @(negedge clk);
    end
    iOrb = tx_bits[tx_bits.size() - 1];
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    cap_en = 1'b0;
    n_cmp++;
    if ({oWord, oAddr, oValid, oFrameStart, oSyncErr, oLock, oFrameCnt} !== '0) begin
      n_err++; $display("FAIL jrst_clear: got w=%h a=%0d lk=%b fc=%0d, want all 0", oWord, oAddr, oLock, oFrameCnt);
    end
    void'(tx_bits.pop_back());
    model_run();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL jrst_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL jrst_ev[%0d]: got %s / want %s", i, fmt_ev(got_q[i]), fmt_ev(exp_q[i]));
      end
    end
    iOrb = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    start_stream();
    add_frame(SYNC, 0, 1'b0);
    add_frame(SYNC, 0, 1'b0);
    run_stream();
    model_run();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL relock_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL relock_ev[%0d]: got %s / want %s", i, fmt_ev(got_q[i]), fmt_ev(exp_q[i]));
      end
    end
    n_cmp++;
    if ({oLock, oFrameCnt} !== {1'b1, 8'd2}) begin
      n_err++; $display("FAIL relock_final: got lock=%b fc=%0d, want lock=1 fc=2", oLock, oFrameCnt);
    end
    jitter = 1'b0;
  endtask

  initial begin
    test_acquire();
    test_reset();
    test_false_marker();
    test_sync_loss();
    test_single_miss();
    test_jitter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/orb_m16_deframer.md
Name: orb_m16_deframer

Overview:
Receive-side counterpart of the M16 orbit frame generator. Recovers bits from the serial orbit line and finds frame sync. Reassembles 12-bit telemetry words and presents each one with its in-frame address and a valid strobe, so a ground-test or loopback path can write the frame into RAM. The block sits on the clk80MHz domain and takes the orbit line directly from a pin.

Parameters:
BIT_DIV, 16, clk cycles per orbit bit (even, >=8)
SYNC_WORD, 12'hE27, frame marker transmitted as word 0 of every frame
FRAME_WORDS, 2048, words per frame including the marker (power of two, matches 11-bit address)
MISS_MAX, 2, consecutive bad markers before lock is dropped

Ports:
clk  in  1  system clock (clk80MHz)
rst  in  1  asynchronous active-low reset
iOrb  in  1  serial orbit line, NRZ, MSB of each word first, asynchronous to clk
oWord  out  12  recovered word
oAddr  out  11  word index within frame, 0 = marker
oValid  out  1  one-clk strobe, oWord/oAddr valid
oFrameStart  out  1  one-clk strobe with word 0 when the marker matched
oSyncErr  out  1  one-clk strobe with word 0 when the marker mismatched while locked
oLock  out  1  high while frame-locked
oFrameCnt  out  8  good-marker counter, wraps 255->0

Behaviour:
- Reset (rst=0, async): state HUNT; all outputs 0; shift register, bit/word/miss/phase counters cleared. Reset mid-frame aborts the frame immediately; no partial word is emitted.
- Input: 2-flop synchronizer on iOrb, plus a third flop for edge detect.
- Bit recovery: phase counter runs 0..BIT_DIV-1 and wraps.
  - A synchronized edge forces phase to 0.
  - When phase == BIT_DIV/2-1, a bit strobe fires and the synchronized level shifts into a 12-bit shift register (LSB in).
  - With no edges, the counter free-runs, so a constant line still yields one bit per BIT_DIV clocks.
- HUNT:
  - Checks the shift register on every bit strobe.
  - When the register equals SYNC_WORD: go to LOCK; emit the word with oAddr=0; pulse oFrameStart; increment oFrameCnt; set wordCnt=1, bitCnt=0, missCnt=0.
  - oValid is never asserted otherwise in HUNT.
- LOCK:
  - bitCnt counts 0..11 on bit strobes.
  - On the 12th bit: emit the shift register as oWord with oAddr=wordCnt, then wordCnt <= wordCnt+1 mod FRAME_WORDS.
  - SYNC_WORD appearing at any nonzero address is ordinary data and is ignored.
- Word 0 in LOCK:
  - Match: pulse oFrameStart, increment oFrameCnt, missCnt <= 0.
  - Mismatch: pulse oSyncErr and increment missCnt. The word is still emitted with oValid and oAddr=0.
  - If the increment makes missCnt == MISS_MAX: same cycle, go to HUNT and drop oLock. HUNT searches starting from the next bit strobe.
- oLock = (state == LOCK); it rises in the same cycle as the first oFrameStart.
- Latency: oValid, oFrameStart and oSyncErr assert on the clk after the bit strobe that completes the word. Strobes last exactly one clk. oWord and oAddr hold until the next strobe.
- Simultaneous events:
  - A sync edge landing on the sample phase: the edge reset wins and that bit is not sampled this cycle.
  - A word completing on the same clk as a transition to HUNT: the word is still emitted.

Test Plan:
- Reset: hold rst=0 with random iOrb -> all outputs 0, oLock=0; release -> no oValid until the marker is seen.
- Acquire: idle line 0, then frame [E27, 001, 002, ..., 7FF] at BIT_DIV=16 -> oValid with addr 0 data E27 plus oFrameStart, then addr 1..2047 data 001..7FF, one word per 192 clks, oLock=1, oFrameCnt=1.
- False marker: E27 placed at word 500 of the second frame -> emitted as data at addr 500; no oFrameStart; wordCnt unaffected.
- Sync loss: two consecutive frames with word 0 = 000 and MISS_MAX=2 -> oSyncErr twice, oLock falls after the second; the next valid frame relocks at addr 0.
- Single miss recovery: one bad marker then a good one -> one oSyncErr, oLock stays 1, missCnt clears.
- Jitter: bit periods alternating 15/17 clks over 3 frames -> all words correct with no oSyncErr. A reset pulse at word 1000 -> outputs clear immediately, and relock occurs on the next marker.
